// File: rtl/inverse_linear_transformation.sv
// Inverse of the 16-segment piecewise-linear colour curve.
// A setup FSM latches the knot values and fills a table of reciprocal
// slopes using one shared restoring divider. After that, a 3-stage
// pipeline maps each curve-domain sample y back to x, one per cycle.
//
// state | meaning
// IDLE  | waiting for cal_begin; table valid when cal_valid=1
// LOAD  | set up numerator/divisor for the current segment
// DIV   | one quotient bit per cycle, QW cycles, no early exit
// STORE | write R_seg, advance segment or finish
module inverse_linear_transformation #(
  parameter int DSIZE    = 12,
  parameter int SEG_LOG2 = 4,
  parameter int DT_I     = 5,
  parameter int DT_D     = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 cal_begin,
  input  logic [17*DSIZE-1:0]  knots,
  output logic                 cal_valid,
  input  logic                 in_valid,
  input  logic [DSIZE-1:0]     indata,
  output logic                 out_valid,
  output logic [DSIZE-1:0]     outdata
);

  localparam int QW   = DT_I + DT_D;
  localparam int NSEG = 16;
  localparam int W    = 1 << SEG_LOG2;
  localparam int CW   = $clog2(QW);
  localparam int PW   = DSIZE + QW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DIV, ST_STORE} state_t;

  state_t             state;
  logic [DSIZE-1:0]   c_q [NSEG+1];
  logic [QW-1:0]      r_q [NSEG];
  logic [3:0]         seg;
  logic [QW-1:0]      num_sr;
  logic [DSIZE:0]     rem;
  logic [DSIZE-1:0]   dvs;
  logic [CW-1:0]      div_cnt;

  logic [DSIZE:0]     trial;
  logic               q_bit;
  logic [DSIZE:0]     rem_nxt;
  logic [QW-1:0]      numer;

  // One restoring-divide step: shift in the next numerator bit and subtract if it fits.
  always_comb begin
    trial   = {rem[DSIZE-1:0], num_sr[QW-1]};
    q_bit   = (trial >= {1'b0, dvs});
    rem_nxt = q_bit ? (trial - {1'b0, dvs}) : trial;
    // The last segment is one code shorter because X_16 = 16*W - 1.
    numer   = (seg == 4'(NSEG-1)) ? (QW'(W-1) << DT_D) : (QW'(W) << DT_D);
  end

  // Setup FSM: knot latch and reciprocal-slope table fill.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= ST_IDLE;
      seg       <= '0;
      cal_valid <= 1'b0;
      num_sr    <= '0;
      rem       <= '0;
      dvs       <= '0;
      div_cnt   <= '0;
      for (int k = 0; k <= NSEG; k++) c_q[k] <= '0;
      for (int k = 0; k < NSEG; k++)  r_q[k] <= '0;
    end else if (cal_begin) begin
      // Valid in any state: a new pulse always restarts from segment 0.
      for (int k = 0; k <= NSEG; k++) c_q[k] <= knots[k*DSIZE +: DSIZE];
      seg       <= '0;
      cal_valid <= 1'b0;
      state     <= ST_LOAD;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_LOAD: begin
          num_sr  <= numer;
          rem     <= '0;
          dvs     <= c_q[{1'b0, seg} + 5'd1] - c_q[{1'b0, seg}];
          div_cnt <= CW'(QW-1);
          state   <= ST_DIV;
        end
        ST_DIV: begin
          num_sr <= {num_sr[QW-2:0], q_bit};
          rem    <= rem_nxt;
          if (div_cnt == '0) state <= ST_STORE;
          else               div_cnt <= div_cnt - 1'b1;
        end
        ST_STORE: begin
          // A flat segment is never selected, so its slope is simply zeroed.
          r_q[seg] <= (dvs == '0) ? '0 : num_sr;
          if (seg == 4'(NSEG-1)) begin
            cal_valid <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            seg   <= seg + 1'b1;
            state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- datapath ----------------
  logic                   v1, v2;
  logic [DSIZE-1:0]       y1;
  logic [3:0]             k1, k2;
  logic                   lo1, hi1, lo2, hi2;
  logic [DSIZE+QW-1:0]    p2;

  logic [3:0]             k_sel;
  logic                   lo_sel, hi_sel;
  logic [DSIZE-1:0]       d_s2;
  logic [DSIZE+QW-1:0]    p_s2;
  logic [PW-1:0]          rnd, span, frac;
  logic [DSIZE-1:0]       x_s3;

  // Segment search: highest k with C_k <= y, so equal knots pick the upper segment.
  always_comb begin
    k_sel = '0;
    for (int i = 1; i < NSEG; i++)
      if (c_q[i] <= indata) k_sel = 4'(i);
    lo_sel = (indata < c_q[0]);
    hi_sel = (indata >= c_q[NSEG]);
  end

  // Offset into the segment times its reciprocal slope.
  always_comb begin
    d_s2 = y1 - c_q[{1'b0, k1}];
    p_s2 = {{QW{1'b0}}, d_s2} * {{DSIZE{1'b0}}, r_q[k1]};
  end

  // Round, saturate at the next breakpoint, add segment base, apply clamps.
  always_comb begin
    rnd  = ({1'b0, p2} + PW'(1 << (DT_D-1))) >> DT_D;
    span = (k2 == 4'(NSEG-1)) ? PW'(W-1) : PW'(W);
    frac = (rnd > span) ? span : rnd;
    if (lo2)      x_s3 = '0;
    else if (hi2) x_s3 = DSIZE'(NSEG*W - 1);
    else          x_s3 = (DSIZE'(k2) << SEG_LOG2) + frac[DSIZE-1:0];
  end

  // Stage 1: register sample and segment decision; accept only with a valid table.
  always_ff @(posedge clock) begin
    if (rst) begin
      v1  <= 1'b0;
      y1  <= '0;
      k1  <= '0;
      lo1 <= 1'b0;
      hi1 <= 1'b0;
    end else begin
      v1  <= in_valid & cal_valid & ~cal_begin;
      y1  <= indata;
      k1  <= k_sel;
      lo1 <= lo_sel;
      hi1 <= hi_sel;
    end
  end

  // Stage 2: register product; recalibration drops in-flight samples.
  always_ff @(posedge clock) begin
    if (rst) begin
      v2  <= 1'b0;
      p2  <= '0;
      k2  <= '0;
      lo2 <= 1'b0;
      hi2 <= 1'b0;
    end else begin
      v2  <= v1 & ~cal_begin;
      p2  <= p_s2;
      k2  <= k1;
      lo2 <= lo1;
      hi2 <= hi1;
    end
  end

  // Stage 3: output register, holds its value between valid samples.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      outdata   <= '0;
    end else begin
      out_valid <= v2 & ~cal_begin;
      if (v2) outdata <= x_s3;
    end
  end

endmodule

// File: tb/tb_inverse_linear_transformation.sv
// Directed bench for inverse_linear_transformation plus a random stream
// checked against a small integer model of the inverse curve.
module tb_inverse_linear_transformation;

  logic          clock = 1'b0;
  logic          rst;
  logic          cal_begin;
  logic [203:0]  knots;
  logic          cal_valid;
  logic          in_valid;
  logic [11:0]   indata;
  logic          out_valid;
  logic [11:0]   outdata;

  int n_cmp = 0;
  int n_err = 0;
  int c [17];
  int exp_q [$];

  inverse_linear_transformation dut (
    .clock     (clock),
    .rst       (rst),
    .cal_begin (cal_begin),
    .knots     (knots),
    .cal_valid (cal_valid),
    .in_valid  (in_valid),
    .indata    (indata),
    .out_valid (out_valid),
    .outdata   (outdata)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_knots();
    for (int k = 0; k < 17; k++) knots[k*12 +: 12] = 12'(c[k]);
  endtask

  task automatic knots_lin(input int step_sz, input int last);
    for (int k = 0; k < 16; k++) c[k] = step_sz * k;
    c[16] = last;
    set_knots();
  endtask

  // Pulse cal_begin and require cal_valid exactly 241 cycles later.
  task automatic do_cal(input string tag);
    int n;
    cal_begin = 1'b1;
    step();
    cal_begin = 1'b0;
    n = 1;
    while (!cal_valid && n < 400) begin
      step();
      n++;
    end
    chk(tag, n, 241);
  endtask

  // Single sample: exact 3-cycle latency, value, and hold afterwards.
  task automatic apply(input string tag, input int y, input int expv);
    in_valid = 1'b1;
    indata   = 12'(y);
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_early"}, out_valid, 0);
    step();
    chk({tag, "_ov"}, out_valid, 1);
    chk(tag, outdata, expv);
    step();
    chk({tag, "_hold"}, outdata, expv);
  endtask

  // Reference inverse curve from the knot array.
  function automatic int model(input int y);
    int k, w, dv, r, p, x;
    if (y >= c[16]) return 255;
    if (y < c[0]) return 0;
    k = 0;
    for (int i = 1; i < 16; i++) if (c[i] <= y) k = i;
    w  = (k == 15) ? 15 : 16;
    dv = c[k+1] - c[k];
    r  = (dv == 0) ? 0 : (w * 256) / dv;
    p  = (y - c[k]) * r;
    x  = (p + 128) / 256;
    if (x > w) x = w;
    return 16 * k + x;
  endfunction

  initial begin
    rst = 1'b1; cal_begin = 1'b0; in_valid = 1'b0; indata = '0; knots = '0;
    repeat (3) step();
    chk("rst_cal_valid", cal_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outdata", outdata, 0);
    rst = 1'b0;

    // no table yet: samples must be ignored
    in_valid = 1'b1; indata = 12'd100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("nocal_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    // T1 identity
    knots_lin(16, 255);
    do_cal("t1_cal_time");
    apply("t1_y100", 100, 100);
    apply("t1_y240", 240, 240);
    apply("t1_y255_hi", 255, 255);

    // T2 gain 2
    knots_lin(32, 510);
    do_cal("t2_cal_time");
    apply("t2_y100", 100, 50);
    apply("t2_y0", 0, 0);
    apply("t2_y600_hi", 600, 255);

    // T3 flat segment
    knots_lin(16, 255);
    c[4] = 48;
    set_knots();
    do_cal("t3_cal_time");
    apply("t3_y48", 48, 64);
    apply("t3_y47", 47, 47);

    // T4 rounding and saturation
    knots_lin(48, 765);
    do_cal("t4_cal_time");
    apply("t4_y3", 3, 1);
    apply("t4_y47", 47, 16);
    apply("t4_y48", 48, 16);

    // T5 lo clamp: C_0 above zero
    knots_lin(16, 255);
    c[0] = 5;
    set_knots();
    do_cal("t5_lo_cal_time");
    apply("t5_y2_lo", 2, 0);

    // T5 restart mid-setup
    knots_lin(16, 255);
    cal_begin = 1'b1;
    step();
    cal_begin = 1'b0;
    chk("restart_cal_drop", cal_valid, 0);
    repeat (99) step();
    chk("restart_mid_cal_valid", cal_valid, 0);
    do_cal("restart_cal_time");
    apply("restart_y100", 100, 100);

    // T5 reset mid-setup
    cal_begin = 1'b1;
    step();
    cal_begin = 1'b0;
    repeat (49) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_cal_valid", cal_valid, 0);
    chk("rst_mid_outdata", outdata, 0);
    repeat (300) step();
    chk("rst_idle_cal_valid", cal_valid, 0);

    // T6 streaming on gain-2 knots
    knots_lin(32, 510);
    do_cal("t6_cal_time");
    for (int i = 0; i < 1003; i++) begin
      if (i >= 3) begin
        chk("stream_ov", out_valid, 1);
        chk("stream_x", outdata, exp_q.pop_front());
      end
      if (i < 1000) begin
        int y;
        y = int'($urandom_range(0, 600));
        in_valid = 1'b1;
        indata   = 12'(y);
        exp_q.push_back(model(y));
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chk("stream_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
